fetch_unit: RTL and testbench

Instruction fetch front end for the RV32i core. It sits directly upstream of the program memory: it generates the byte address the memory reads and captures the instruction returned one cycle later. It buffers that instruction in a 2-entry queue and presents it to decode over a valid/ready handshake. Program-counter redirects (branches and jumps) from execute flush all queued and in-flight fetches.

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32i instruction fetch front end with a 2-entry decode queue
module fetch_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] q_instr [2];
    logic [ADDR_WIDTH-1:0] q_pc [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            cnt;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occ;

    assign mem_addr    = pc;
    assign instr_valid = cnt != 2'd0;
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    // Handshake and issue decision; occ counts slots already promised to queued or in-flight words
    always_comb begin
        pop   = instr_valid & instr_ready & ~redirect_valid;
        push  = resp_valid & ~redirect_valid;
        occ   = {1'b0, cnt} + {2'b0, resp_valid} - {2'b0, pop};
        issue = ~redirect_valid & (occ < 3'd2);
    end

    // Fetch address and in-flight response tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc & ~ADDR_WIDTH'(3);
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= issue;
            if (issue) begin
                pc      <= pc + ADDR_WIDTH'(4);
                resp_pc <= pc;
            end
        end
    end

    // Two-entry instruction queue; a redirect empties it and drops the in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= mem_data;
                q_pc[wr_ptr]    <= resp_pc;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector bench for fetch_unit with a registered program memory model
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_ready;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [9:0]  rpc;
        logic        ev;
        logic [31:0] ei;
        logic [9:0]  ep;
        logic [9:0]  ea;
        logic        full;
    } vec_t;

    vec_t vecs[34];

    fetch_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(10'h000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: word k holds 0x1000+k, read data registered
    always @(posedge clk) mem_data <= 32'h1000 + {24'h0, mem_addr[9:2]};

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [9:0] rpc,
                                input logic ev, input logic [31:0] ei, input logic [9:0] ep,
                                input logic [9:0] ea, input logic full);
        vec_t v;
        v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #2 rst_n = 1'b0;

        vecs[0]  = mk(0, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h000, 1);
        vecs[1]  = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h000, 1);
        vecs[2]  = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h004, 0);
        vecs[3]  = mk(1, 1, 0, 10'h000, 1, 32'h1000, 10'h000, 10'h008, 0);
        vecs[4]  = mk(1, 1, 0, 10'h000, 1, 32'h1001, 10'h004, 10'h00C, 0);
        vecs[5]  = mk(1, 1, 0, 10'h000, 1, 32'h1002, 10'h008, 10'h010, 0);
        vecs[6]  = mk(1, 0, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[7]  = mk(1, 0, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[8]  = mk(1, 0, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[9]  = mk(1, 0, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[10] = mk(1, 0, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[11] = mk(1, 1, 0, 10'h000, 1, 32'h1003, 10'h00C, 10'h014, 0);
        vecs[12] = mk(1, 1, 0, 10'h000, 1, 32'h1004, 10'h010, 10'h018, 0);
        vecs[13] = mk(1, 1, 0, 10'h000, 1, 32'h1005, 10'h014, 10'h01C, 0);
        vecs[14] = mk(1, 0, 0, 10'h000, 1, 32'h1006, 10'h018, 10'h020, 0);
        vecs[15] = mk(1, 1, 1, 10'h040, 1, 32'h1006, 10'h018, 10'h020, 0);
        vecs[16] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h040, 0);
        vecs[17] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h044, 0);
        vecs[18] = mk(1, 1, 0, 10'h000, 1, 32'h1010, 10'h040, 10'h048, 0);
        vecs[19] = mk(1, 1, 1, 10'h043, 1, 32'h1011, 10'h044, 10'h04C, 0);
        vecs[20] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h040, 0);
        vecs[21] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h044, 0);
        vecs[22] = mk(1, 1, 1, 10'h100, 1, 32'h1010, 10'h040, 10'h048, 0);
        vecs[23] = mk(1, 1, 1, 10'h3FC, 0, 32'h0,    10'h000, 10'h100, 0);
        vecs[24] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h3FC, 0);
        vecs[25] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h000, 0);
        vecs[26] = mk(1, 1, 0, 10'h000, 1, 32'h10FF, 10'h3FC, 10'h004, 0);
        vecs[27] = mk(1, 0, 0, 10'h000, 1, 32'h1000, 10'h000, 10'h008, 0);
        vecs[28] = mk(1, 0, 0, 10'h000, 1, 32'h1000, 10'h000, 10'h008, 0);
        vecs[29] = mk(0, 0, 0, 10'h000, 0, 32'h0,    10'h000, 10'h000, 1);
        vecs[30] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h000, 1);
        vecs[31] = mk(1, 1, 0, 10'h000, 0, 32'h0,    10'h000, 10'h004, 0);
        vecs[32] = mk(1, 1, 0, 10'h000, 1, 32'h1000, 10'h000, 10'h008, 0);
        vecs[33] = mk(1, 1, 0, 10'h000, 1, 32'h1001, 10'h004, 10'h00C, 0);

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            instr_ready = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d instr_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("v%0d mem_addr", i), {22'h0, mem_addr}, {22'h0, vecs[i].ea});
            if (vecs[i].ev || vecs[i].full) begin
                chk($sformatf("v%0d instr", i), instr, vecs[i].ei);
                chk($sformatf("v%0d instr_pc", i), {22'h0, instr_pc}, {22'h0, vecs[i].ep});
            end
        end

        // Redirect to 0x200 and measure cycles until the first valid instruction
        @(negedge clk);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc = '0;
        n = 1;
        #1;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("redirect latency", n, 3);
        chk("redirect instr", instr, 32'h1080);
        chk("redirect instr_pc", {22'h0, instr_pc}, 32'h200);

        // Stall for six cycles: head and fetch address must freeze
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_ready = 1'b0;
            #1;
            chk($sformatf("stall%0d instr", i), instr, 32'h1081);
            chk($sformatf("stall%0d instr_pc", i), {22'h0, instr_pc}, 32'h204);
            chk($sformatf("stall%0d mem_addr", i), {22'h0, mem_addr}, 32'h20C);
        end

        // Release: delivery resumes immediately with no gap or repeat
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            chk($sformatf("release%0d valid", i), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("release%0d instr", i), instr, 32'h1081 + i);
            chk($sformatf("release%0d instr_pc", i), {22'h0, instr_pc}, 32'h204 + 4 * i);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
